// File: rtl/uart_pkg.sv
// Shared UART receive-control definitions: controller state encoding and receiver config field layout.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } rx_state_t;

    localparam int CFG_PARITY_BIT  = 0;
    localparam int CFG_STOP_LSB    = 1;
    localparam int CFG_STOP_WIDTH  = 2;
    localparam int CFG_DATA_LSB    = 3;
    localparam int CFG_DATA_WIDTH  = 2;
    localparam int DATA_LEN_OFFSET = 4;

    // Data-length code 0..3 maps to 4..7 data bits plus offset.
    function automatic int cfg_data_bits(input logic [4:0] cfg);
        return int'(cfg[CFG_DATA_LSB +: CFG_DATA_WIDTH]) + DATA_LEN_OFFSET;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Host-side bus of the UART receive controller: config write, run request, FIFO read port and status flags.
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int CONF_WIDTH  = 5,
    parameter int LEVEL_WIDTH = 3
);
    logic                   enable_i;
    logic                   cfg_valid_i;
    logic [CONF_WIDTH-1:0]  cfg_i;
    logic                   cfg_ready_o;
    logic                   rd_valid_o;
    logic                   rd_ready_i;
    logic [DATA_WIDTH-1:0]  rd_data_o;
    logic                   rd_perr_o;
    logic [LEVEL_WIDTH-1:0] level_o;
    logic                   overrun_o;
    logic                   perr_o;
    logic                   clr_flags_i;

    modport slave (
        input  enable_i, cfg_valid_i, cfg_i, rd_ready_i, clr_flags_i,
        output cfg_ready_o, rd_valid_o, rd_data_o, rd_perr_o, level_o, overrun_o, perr_o
    );

    modport master (
        output enable_i, cfg_valid_i, cfg_i, rd_ready_i, clr_flags_i,
        input  cfg_ready_o, rd_valid_o, rd_data_o, rd_perr_o, level_o, overrun_o, perr_o
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead capture FIFO: head word always visible on rd_data; push while full is accepted only with a same-cycle pop.
module uart_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Storage is reset so the head reads zero out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: run/stop sequencing with quiescence guard, frame capture FIFO and sticky error flags.
// Build option UART_RX_CTRL_PARITY_DROP_EN: discard frames that arrive with a parity error.
//
// state   | meaning
// ST_OFF  | receiver disabled, config writes accepted
// ST_RUN  | receiver enabled, config locked
// ST_STOP | receiver disabled, waiting GUARD_TICKS baud ticks for the line to settle
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int MAX_DATA_WIDTH  = 8,
    parameter int STOP_CONF_WIDTH = 2,
    parameter int DATA_CONF_WIDTH = 3,
    parameter int FIFO_DEPTH      = 4,
    parameter int GUARD_TICKS     = 256,
    localparam int CONF_W         = STOP_CONF_WIDTH + DATA_CONF_WIDTH,
    localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      baud_en_i,
    output logic                      rx_en_o,
    output logic [CONF_W-1:0]         rx_conf_o,
    input  logic                      rx_done_i,
    input  logic                      parity_error_i,
    input  logic [MAX_DATA_WIDTH-1:0] rx_data_i,
    uart_rx_ctrl_if.slave             bus
);

    localparam int GUARD_W = (GUARD_TICKS > 1) ? $clog2(GUARD_TICKS) : 1;
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_TICKS - 1);
`ifdef UART_RX_CTRL_PARITY_DROP_EN
    localparam int FIFO_W = MAX_DATA_WIDTH;
`else
    localparam int FIFO_W = MAX_DATA_WIDTH + 1;
`endif

    rx_state_t          state_q;
    rx_state_t          state_d;
    logic [GUARD_W-1:0] guard_q;
    logic [GUARD_W-1:0] guard_d;
    logic               conf_load;

    logic               done_q;
    logic               frame_rise;
    logic               push_req;
    logic               pop;
    logic               full;
    logic               empty;
    logic               push_accept;
    logic               overrun_set;
    logic               perr_set;
    logic               overrun_q;
    logic               perr_q;
    logic [FIFO_W-1:0]  wr_word;
    logic [FIFO_W-1:0]  head;
    logic [LVL_W-1:0]   level;

    // Guard timer counts down from GUARD_TICKS-1; the tick seen at zero releases to OFF.
    always_comb begin
        state_d   = state_q;
        guard_d   = guard_q;
        conf_load = 1'b0;
        case (state_q)
            ST_OFF: begin
                conf_load = bus.cfg_valid_i;
                if (bus.enable_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.enable_i) begin
                    state_d = ST_STOP;
                    guard_d = GUARD_LOAD;
                end
            end
            ST_STOP: begin
                if (bus.enable_i) begin
                    state_d = ST_RUN;
                    guard_d = GUARD_LOAD;
                end else if (baud_en_i) begin
                    if (guard_q == '0) begin
                        state_d = ST_OFF;
                    end else begin
                        guard_d = guard_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
                guard_d = GUARD_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_OFF;
            guard_q   <= GUARD_LOAD;
            rx_conf_o <= '0;
        end else begin
            state_q <= state_d;
            guard_q <= guard_d;
            if (conf_load) begin
                rx_conf_o <= bus.cfg_i;
            end
        end
    end

    assign rx_en_o         = (state_q == ST_RUN);
    assign bus.cfg_ready_o = (state_q == ST_OFF);

    assign frame_rise  = rx_done_i & ~done_q;
    assign pop         = ~empty & bus.rd_ready_i;
    assign push_accept = ~full | pop;

`ifdef UART_RX_CTRL_PARITY_DROP_EN
    assign push_req      = frame_rise & ~parity_error_i;
    assign perr_set      = frame_rise & parity_error_i;
    assign wr_word       = rx_data_i;
    assign bus.rd_data_o = head;
    assign bus.rd_perr_o = 1'b0;
`else
    assign push_req      = frame_rise;
    assign perr_set      = frame_rise & parity_error_i & push_accept;
    assign wr_word       = {parity_error_i, rx_data_i};
    assign bus.rd_data_o = head[MAX_DATA_WIDTH-1:0];
    assign bus.rd_perr_o = head[MAX_DATA_WIDTH];
`endif

    assign overrun_set = push_req & ~push_accept;

    // A set event in the same cycle as a clear leaves the flag asserted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            done_q    <= rx_done_i;
            overrun_q <= overrun_set | (overrun_q & ~bus.clr_flags_i);
            perr_q    <= perr_set | (perr_q & ~bus.clr_flags_i);
        end
    end

    uart_rx_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (push_req),
        .pop     (pop),
        .wr_data (wr_word),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .rd_data (head)
    );

    assign bus.rd_valid_o = ~empty;
    assign bus.level_o    = level;
    assign bus.overrun_o  = overrun_q;
    assign bus.perr_o     = perr_q;

endmodule
